// File: rtl/sha256_msg_sched.sv
// Feeds pre-padded messages to a chained-mode SHA-256 core one 512-bit block at a time,
// loops each intermediate hash back as h_i and presents the final digest on a valid/ready port.
module sha256_msg_sched #(
    parameter int N      = 32,
    parameter int WD_MAX = 200
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    s_data_i,
    input  logic            s_valid_i,
    input  logic            s_last_i,
    output logic            s_ready_o,
    output logic [16*N-1:0] core_m_o,
    output logic [8*N-1:0]  core_h_o,
    output logic            core_clr_o,
    input  logic            core_end_i,
    input  logic [8*N-1:0]  core_hash_i,
    output logic [8*N-1:0]  d_digest_o,
    output logic            d_valid_o,
    input  logic            d_ready_i,
    output logic            busy_o,
    output logic            err_o
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, CAPT, OUT} state_t;

    localparam int            WW      = $clog2(WD_MAX + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_MAX - 1);
    localparam logic [8*N-1:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    state_t             state, state_nx;
    logic [0:15][N-1:0] m_q;
    logic [8*N-1:0]     h_q, cap_q, dig_q;
    logic [3:0]         cnt;
    logic [WW-1:0]      wd;
    logic               last_q, rdy_q, dv_q, err_q;
    logic               accept, end_ok, wd_hit;

    assign accept = s_valid_i & rdy_q;
    // wd is still 0 in the first RUN cycle, so a flag left over from the previous block is ignored
    assign end_ok = core_end_i & (wd != '0);
    assign wd_hit = (wd == WD_LAST);

    assign s_ready_o  = rdy_q;
    assign core_m_o   = m_q;
    assign core_h_o   = h_q;
    assign core_clr_o = (state == START);
    assign d_digest_o = dig_q;
    assign d_valid_o  = dv_q;
    assign busy_o     = (state != IDLE);
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = LOAD;
            LOAD:  if (accept && cnt == 4'd15) state_nx = START;
            START: state_nx = RUN;
            RUN: begin
                if (end_ok)      state_nx = CAPT;
                else if (wd_hit) state_nx = IDLE;
            end
            CAPT:  state_nx = last_q ? OUT : LOAD;
            OUT:   if (dv_q && d_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_q    <= '0;
            h_q    <= IV;
            cap_q  <= '0;
            dig_q  <= '0;
            cnt    <= '0;
            wd     <= '0;
            last_q <= 1'b0;
            rdy_q  <= 1'b0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // registered so ready stays low in reset and only rises the cycle after leaving OUT
            rdy_q <= (state_nx == IDLE) || (state_nx == LOAD);
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_q[0] <= s_data_i;
                        cnt    <= 4'd1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        m_q[cnt] <= s_data_i;
                        cnt      <= cnt + 4'd1;
                        if (cnt == 4'd15) last_q <= s_last_i;
                    end
                end
                START: wd <= '0;
                RUN: begin
                    wd <= wd + 1'b1;
                    if (end_ok) begin
                        cap_q <= core_hash_i;
                    end else if (wd_hit) begin
                        err_q <= 1'b1;
                        h_q   <= IV;
                    end
                end
                CAPT: begin
                    if (!last_q) begin
                        h_q <= cap_q;
                        cnt <= '0;
                    end else begin
                        dig_q <= cap_q;
                        dv_q  <= 1'b1;
                    end
                end
                OUT: begin
                    if (dv_q && d_ready_i) begin
                        dv_q <= 1'b0;
                        h_q  <= IV;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a behavioural chained SHA-256 core attached.
module tb_sha256_msg_sched;

    localparam int N        = 32;
    localparam int WD_MAX   = 200;
    localparam int CORE_LAT = 20;

    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                        32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    localparam logic [511:0] B1_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2_BLK = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                        32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic [N-1:0]   s_data_i;
    logic           s_valid_i, s_last_i, s_ready_o;
    logic [16*N-1:0] core_m_o;
    logic [8*N-1:0] core_h_o, core_hash_i, d_digest_o;
    logic           core_clr_o, core_end_i, d_valid_o, d_ready_i, busy_o, err_o;

    int tests = 0;
    int fails = 0;

    sha256_msg_sched #(.N(N), .WD_MAX(WD_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .core_m_o(core_m_o), .core_h_o(core_h_o), .core_clr_o(core_clr_o),
        .core_end_i(core_end_i), .core_hash_i(core_hash_i),
        .d_digest_o(d_digest_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_cmp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {h, g, f, e, d, c, b, a} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + h, hin[223:192] + g, hin[191:160] + f, hin[159:128] + e,
                hin[127:96] + d, hin[95:64] + c, hin[63:32] + b, hin[31:0] + a};
    endfunction

    // Core model: latches m/h on the restart pulse, answers after CORE_LAT cycles and
    // keeps fl_end high until one cycle after the next restart (stale flag).
    bit           hang = 1'b0;
    int           lat_cnt, blk_n = 0, cur;
    bit           clr_seen;
    logic [511:0] m_lat;
    logic [255:0] h_lat;
    logic [255:0] h_hist [8];
    logic [255:0] o_hist [8];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            core_end_i  <= 1'b0;
            core_hash_i <= '0;
            lat_cnt     <= 0;
            clr_seen    <= 1'b0;
        end else begin
            clr_seen <= core_clr_o;
            if (core_clr_o) begin
                m_lat           <= core_m_o;
                h_lat           <= core_h_o;
                lat_cnt         <= CORE_LAT;
                h_hist[blk_n&7] <= core_h_o;
                cur             <= blk_n;
                blk_n           <= blk_n + 1;
            end else if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1 && !hang) begin
                    core_end_i    <= 1'b1;
                    core_hash_i   <= sha_cmp(h_lat, m_lat);
                    o_hist[cur&7] <= sha_cmp(h_lat, m_lat);
                end
            end
            if (clr_seen) core_end_i <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at the negedge after the last accepted word.
    task automatic send_block(input logic [511:0] blk, input bit last, input int nw,
                              input int maxgap, input int junk, output bit ok);
        int t;
        ok = 1'b1;
        for (int i = 0; i < nw; i++) begin
            if (maxgap > 0)
                repeat ($urandom_range(maxgap, 0)) begin s_valid_i = 1'b0; @(negedge clk_i); end
            s_valid_i = 1'b1;
            s_data_i  = blk[511-32*i -: 32];
            s_last_i  = (i == 15) ? last : (i == junk);
            t = 0;
            while (!s_ready_o && t < 1000) begin @(negedge clk_i); t++; end
            if (!s_ready_o) ok = 1'b0;
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_digest(output bit ok, output bit rdy_seen);
        int t;
        t = 0;
        rdy_seen = 1'b0;
        while (!d_valid_o && t < 1000) begin
            if (s_ready_o) rdy_seen = 1'b1;
            @(negedge clk_i);
            t++;
        end
        if (s_ready_o) rdy_seen = 1'b1;
        ok = d_valid_o;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_i);
        tests++;
        if ({s_ready_o, core_clr_o, d_valid_o, err_o, busy_o} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {s_ready_o, core_clr_o, d_valid_o, err_o, busy_o});
        end
        tests++;
        if (core_h_o !== IV) begin fails++; $display("FAIL reset_h: got %h want %h", core_h_o, IV); end
        tests++;
        if (core_m_o !== '0 || d_digest_o !== '0) begin
            fails++; $display("FAIL reset_m_digest: got m=%h d=%h want 0", core_m_o, d_digest_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if ({s_ready_o, busy_o} !== 2'b10) begin
            fails++; $display("FAIL idle_ready: got %b want 10", {s_ready_o, busy_o});
        end
    endtask

    task automatic test_abc;
        bit ok;
        int base, t;
        base = blk_n;
        send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL abc_send: got timeout want accept"); end
        tests++;
        if ({core_clr_o, s_ready_o, busy_o} !== 3'b101 || core_m_o !== ABC_BLK || core_h_o !== IV) begin
            fails++; $display("FAIL abc_start: got clr/rdy/busy=%b m=%h h=%h want 101, abc block, IV",
                              {core_clr_o, s_ready_o, busy_o}, core_m_o, core_h_o);
        end
        t = 0;
        while (!core_end_i && t < 1000) begin @(negedge clk_i); t++; end
        tests++;
        if (core_end_i !== 1'b1) begin fails++; $display("FAIL abc_core_end: got %b want 1", core_end_i); end
        @(negedge clk_i);
        tests++;
        if (d_valid_o !== 1'b0) begin fails++; $display("FAIL abc_lat1: got d_valid %b want 0", d_valid_o); end
        @(negedge clk_i);
        tests++;
        if (d_valid_o !== 1'b1) begin fails++; $display("FAIL abc_lat2: got d_valid %b want 1", d_valid_o); end
        tests++;
        if (d_digest_o !== ABC_DIG || s_ready_o !== 1'b0) begin
            fails++; $display("FAIL abc_digest: got %h rdy=%b want %h rdy=0", d_digest_o, s_ready_o, ABC_DIG);
        end
        @(negedge clk_i);
        tests++;
        if ({d_valid_o, s_ready_o} !== 2'b01 || blk_n - base != 1) begin
            fails++; $display("FAIL abc_after: got dv/rdy=%b clr_pulses=%0d want 01 and 1", {d_valid_o, s_ready_o}, blk_n - base);
        end
    endtask

    task automatic test_two_block;
        bit ok, ok2, rdy;
        int base;
        base = blk_n;
        send_block(B1_BLK, 1'b0, 16, 0, 5, ok);
        tests++;
        if (!ok || core_clr_o !== 1'b1 || core_h_o !== IV) begin
            fails++; $display("FAIL two_b1_start: got ok=%b clr=%b h=%h want 1 1 IV", ok, core_clr_o, core_h_o);
        end
        send_block(B2_BLK, 1'b1, 16, 0, -1, ok);
        tests++;
        if (!ok || core_clr_o !== 1'b1 || core_m_o !== B2_BLK || core_h_o !== o_hist[base&7]) begin
            fails++; $display("FAIL two_b2_chain: got clr=%b h=%h want 1 h=%h", core_clr_o, core_h_o, o_hist[base&7]);
        end
        wait_digest(ok2, rdy);
        tests++;
        if (!ok2 || rdy || d_digest_o !== TWO_DIG) begin
            fails++; $display("FAIL two_digest: got ok=%b rdy_seen=%b d=%h want 1 0 %h", ok2, rdy, d_digest_o, TWO_DIG);
        end
        @(negedge clk_i);
        tests++;
        if (blk_n - base != 2 || s_ready_o !== 1'b1) begin
            fails++; $display("FAIL two_pulses: got %0d rdy=%b want 2 1", blk_n - base, s_ready_o);
        end
    endtask

    task automatic test_stall;
        bit ok, ok2, rdy, stable;
        logic [255:0] saved;
        d_ready_i = 1'b0;
        send_block(ABC_BLK, 1'b1, 16, 3, -1, ok);
        wait_digest(ok2, rdy);
        tests++;
        if (!ok || !ok2 || rdy) begin
            fails++; $display("FAIL stall_wait: got ok=%b%b rdy_seen=%b want 11 0", ok, ok2, rdy);
        end
        saved  = d_digest_o;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (d_valid_o !== 1'b1 || d_digest_o !== saved || s_ready_o !== 1'b0) stable = 1'b0;
        end
        tests++;
        if (!stable) begin fails++; $display("FAIL stall_hold: got unstable output want held digest"); end
        d_ready_i = 1'b1;
        tests++;
        if (d_digest_o !== ABC_DIG || s_ready_o !== 1'b0) begin
            fails++; $display("FAIL stall_digest: got %h rdy=%b want %h rdy=0", d_digest_o, s_ready_o, ABC_DIG);
        end
        @(negedge clk_i);
        tests++;
        if ({d_valid_o, s_ready_o} !== 2'b01) begin
            fails++; $display("FAIL stall_release: got dv/rdy=%b want 01", {d_valid_o, s_ready_o});
        end
    endtask

    task automatic test_watchdog;
        bit ok, ok2, rdy;
        hang = 1'b1;
        send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
        repeat (WD_MAX) @(negedge clk_i);
        tests++;
        if (!ok || {err_o, busy_o} !== 2'b01) begin
            fails++; $display("FAIL wd_early: got ok=%b err/busy=%b want 1 01", ok, {err_o, busy_o});
        end
        @(negedge clk_i);
        tests++;
        if ({err_o, busy_o, d_valid_o} !== 3'b100 || core_h_o !== IV) begin
            fails++; $display("FAIL wd_fire: got err/busy/dv=%b h=%h want 100 IV", {err_o, busy_o, d_valid_o}, core_h_o);
        end
        hang = 1'b0;
        send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
        wait_digest(ok2, rdy);
        tests++;
        if (!ok || !ok2 || d_digest_o !== ABC_DIG || err_o !== 1'b1) begin
            fails++; $display("FAIL wd_recover: got d=%h err=%b want %h err=1", d_digest_o, err_o, ABC_DIG);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
        bit ok, ok2, rdy;
        send_block(ABC_BLK, 1'b1, 8, 0, -1, ok);
        rst_i = 1'b0;
        #1;
        tests++;
        if (!ok || {s_ready_o, core_clr_o, d_valid_o, err_o, busy_o} !== 5'b0 || core_h_o !== IV ||
            core_m_o !== '0 || d_digest_o !== '0) begin
            fails++; $display("FAIL rst_load: got ctrl=%b h=%h m=%h want 00000 IV 0",
                              {s_ready_o, core_clr_o, d_valid_o, err_o, busy_o}, core_h_o, core_m_o);
        end
        @(negedge clk_i); rst_i = 1'b1; @(negedge clk_i);
        send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
        repeat (3) @(negedge clk_i);
        tests++;
        if (!ok || busy_o !== 1'b1 || s_ready_o !== 1'b0) begin
            fails++; $display("FAIL rst_pre_run: got busy=%b rdy=%b want 1 0", busy_o, s_ready_o);
        end
        rst_i = 1'b0;
        #1;
        tests++;
        if ({s_ready_o, core_clr_o, d_valid_o, err_o, busy_o} !== 5'b0 || core_h_o !== IV || d_digest_o !== '0) begin
            fails++; $display("FAIL rst_run: got ctrl=%b h=%h want 00000 IV",
                              {s_ready_o, core_clr_o, d_valid_o, err_o, busy_o}, core_h_o);
        end
        @(negedge clk_i); rst_i = 1'b1; @(negedge clk_i);
        send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
        wait_digest(ok2, rdy);
        tests++;
        if (!ok || !ok2 || d_digest_o !== ABC_DIG) begin
            fails++; $display("FAIL rst_recover: got %h want %h", d_digest_o, ABC_DIG);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back;
        bit ok, ok2, rdy;
        d_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_block(ABC_BLK, 1'b1, 16, 0, -1, ok);
            tests++;
            if (!ok || core_h_o !== IV) begin
                fails++; $display("FAIL b2b_h%0d: got %h want %h", k, core_h_o, IV);
            end
            wait_digest(ok2, rdy);
            tests++;
            if (!ok2 || d_digest_o !== ABC_DIG || s_ready_o !== 1'b0) begin
                fails++; $display("FAIL b2b_digest%0d: got %h rdy=%b want %h rdy=0", k, d_digest_o, s_ready_o, ABC_DIG);
            end
            @(negedge clk_i);
            tests++;
            if ({d_valid_o, s_ready_o} !== 2'b01) begin
                fails++; $display("FAIL b2b_ready%0d: got dv/rdy=%b want 01", k, {d_valid_o, s_ready_o});
            end
        end
    endtask

    initial begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        d_ready_i = 1'b1;
        test_reset;
        test_abc;
        test_two_block;
        test_stall;
        test_watchdog;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
